// File: rtl/imem_pkg.sv
// imem_pkg: shared constants, FSM states and address fault classification for imem_fetch_port.
package imem_pkg;
  localparam int ADDR_W = 128;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE = 2'b10;
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL = 1'b1;
  // addr is zero-extended to ADDR_W, so Width up to ADDR_W is supported
  function automatic logic [1:0] fault_of(input logic [ADDR_W-1:0] addr, input int aw);
    return addr[1:0] != 2'b00 ? FAULT_MISALIGN : (addr >> (aw + 2)) != '0 ? FAULT_RANGE : FAULT_NONE;
  endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: Width x Depth simple dual-port RAM, synchronous read, read-before-write.
module imem_array #(
  parameter int Width = 32,
  parameter int Depth = 1024,
  localparam int AW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/imem_fetch_port.sv
// imem_fetch_port: instruction memory with valid/ready fetch port, one-entry response register
// and a word-write load port; faulting fetches return NOP, faulting loads pulse load_err_o.
module imem_fetch_port
  import imem_pkg::*;
#(
  parameter int Width = 32,
  parameter int Depth = 1024
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [Width-1:0] req_addr_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [Width-1:0] rsp_instr_o,
  output logic [1:0]       rsp_fault_o,
  input  logic             load_en_i,
  input  logic [Width-1:0] load_addr_i,
  input  logic [Width-1:0] load_data_i,
  output logic             load_err_o
);
  localparam int AW = $clog2(Depth);
  logic [0:0] state_q, state_d;
  logic [1:0] fault_q, fault_d, req_fault, load_fault;
  logic load_err_q, load_err_d, accept, load_we;
  logic [Width-1:0] rdata;
  always_comb begin
    req_fault = fault_of(ADDR_W'(req_addr_i), AW);
    load_fault = fault_of(ADDR_W'(load_addr_i), AW);
    req_ready_o = state_q == EMPTY || rsp_ready_i;
    accept = req_valid_i && req_ready_o && !reset_i;
    load_we = load_en_i && load_fault == FAULT_NONE && !reset_i;
    state_d = accept || (state_q == FULL && !rsp_ready_i) ? FULL : EMPTY;
    fault_d = accept ? req_fault : fault_q;
    load_err_d = load_en_i && load_fault != FAULT_NONE;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= EMPTY;
      fault_q <= FAULT_NONE;
      load_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      load_err_q <= load_err_d;
    end
  end
  // the RAM read register only advances on accept, so a stalled response holds its data
  imem_array #(.Width(Width), .Depth(Depth)) u_array (
    .clk_i   (clk_i),
    .we_i    (load_we),
    .waddr_i (load_addr_i[AW+1:2]),
    .wdata_i (load_data_i),
    .re_i    (accept),
    .raddr_i (req_addr_i[AW+1:2]),
    .rdata_o (rdata)
  );
  assign rsp_valid_o = state_q == FULL;
  assign rsp_fault_o = fault_q;
  assign rsp_instr_o = state_q == FULL && fault_q == FAULT_NONE ? rdata : Width'(NOP);
  assign load_err_o = load_err_q;
endmodule

// File: tb/tb_imem_fetch_port.sv
// tb_imem_fetch_port: table-driven directed checks plus randomized traffic against a behavioural model.
module tb_imem_fetch_port;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP_W = 32'h0000_0013;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, load_en = 1'b0, load_err;
  logic [31:0] req_addr = '0, rsp_instr, load_addr = '0, load_data = '0;
  logic [1:0] rsp_fault;
  int total = 0, bad = 0;
  logic [31:0] mem [16];
  typedef struct { logic [31:0] addr; logic [31:0] instr; logic [1:0] fault; } vec_t;
  vec_t vecs [8];
  imem_fetch_port #(.Width(32), .Depth(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_instr_o(rsp_instr), .rsp_fault_o(rsp_fault), .load_en_i(load_en),
    .load_addr_i(load_addr), .load_data_i(load_data), .load_err_o(load_err)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endfunction
  function automatic logic [1:0] exp_fault(input logic [31:0] a);
    if (a % 4 != 0) return 2'b01;
    if (a >= 32'(4 * DEPTH)) return 2'b10;
    return 2'b00;
  endfunction
  function automatic logic [31:0] rnd_addr();
    int m = $urandom_range(0, 7);
    if (m < 5) return 32'($urandom_range(0, 15)) * 4;
    if (m == 5) return ($urandom & ~32'h3) | 32'($urandom_range(1, 3));
    if (m == 6) return 32'(4 * DEPTH) + 32'($urandom_range(0, 255)) * 4;
    return $urandom | 32'h8000_0000;
  endfunction
  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask
  task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ef);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk({name, ".valid"}, 32'(rsp_valid), 32'd1);
    chk({name, ".instr"}, rsp_instr, ei);
    chk({name, ".fault"}, 32'(rsp_fault), 32'(ef));
  endtask
  initial begin
    logic m_valid, m_err, exp_ready;
    logic [31:0] m_instr;
    logic [1:0] m_fault, f;
    step(); step();
    reset = 1'b0;
    chk("rst.valid", 32'(rsp_valid), 32'd0);
    chk("rst.instr", rsp_instr, NOP_W);
    chk("rst.fault", 32'(rsp_fault), 32'd0);
    chk("rst.load_err", 32'(load_err), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    load(32'h0, 32'h1111_1111);
    chk("load.ok_err", 32'(load_err), 32'd0);
    load(32'h4, 32'h2222_2222);
    load(32'h8, 32'h3333_3333);
    load(32'hFFC, 32'h0CAF_E0FC);
    vecs[0] = '{32'h0, 32'h1111_1111, 2'b00};
    vecs[1] = '{32'h4, 32'h2222_2222, 2'b00};
    vecs[2] = '{32'h2, NOP_W, 2'b01};
    vecs[3] = '{32'h1000, NOP_W, 2'b10};
    vecs[4] = '{32'h1002, NOP_W, 2'b01};
    vecs[5] = '{32'hFFC, 32'h0CAF_E0FC, 2'b00};
    vecs[6] = '{32'hFFFF_FFFC, NOP_W, 2'b10};
    vecs[7] = '{32'h8, 32'h3333_3333, 2'b00};
    req_valid = 1'b1; rsp_ready = 1'b1;
    foreach (vecs[i]) begin
      req_addr = vecs[i].addr;
      #1 chk($sformatf("vec%0d.ready", i), 32'(req_ready), 32'd1);
      step();
      chk($sformatf("vec%0d.valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("vec%0d.instr", i), rsp_instr, vecs[i].instr);
      chk($sformatf("vec%0d.fault", i), 32'(rsp_fault), 32'(vecs[i].fault));
    end
    req_valid = 1'b0;
    step();
    chk("drain.valid", 32'(rsp_valid), 32'd0);
    fetch("bp.first", 32'h4, 32'h2222_2222, 2'b00);
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.ready", 32'(req_ready), 32'd0);
      chk("bp.valid", 32'(rsp_valid), 32'd1);
      chk("bp.instr", rsp_instr, 32'h2222_2222);
    end
    rsp_ready = 1'b1;
    #1 chk("bp.release_ready", 32'(req_ready), 32'd1);
    step();
    chk("bp.next_instr", rsp_instr, 32'h1111_1111);
    req_valid = 1'b0;
    step();
    chk("bp.empty", 32'(rsp_valid), 32'd0);
    load_en = 1'b1; load_addr = 32'h8; load_data = 32'hDEAD_BEEF;
    fetch("rbw.old", 32'h8, 32'h3333_3333, 2'b00);
    load_en = 1'b0;
    fetch("rbw.new", 32'h8, 32'hDEAD_BEEF, 2'b00);
    load(32'h6, 32'h0BAD_0006);
    chk("lerr.mis_pulse", 32'(load_err), 32'd1);
    step();
    chk("lerr.mis_clear", 32'(load_err), 32'd0);
    load(32'h1000, 32'h0BAD_1000);
    chk("lerr.rng_pulse", 32'(load_err), 32'd1);
    fetch("lerr.word1", 32'h4, 32'h2222_2222, 2'b00);
    chk("lerr.rng_clear", 32'(load_err), 32'd0);
    fetch("lerr.word0", 32'h0, 32'h1111_1111, 2'b00);
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      load(32'(i * 4), mem[i]);
    end
    step();
    m_valid = 1'b0; m_err = 1'b0; m_instr = NOP_W; m_fault = 2'b00;
    for (int n = 0; n < 400; n++) begin
      req_valid = $urandom_range(0, 1) == 1;
      rsp_ready = $urandom_range(0, 3) != 0;
      load_en = $urandom_range(0, 2) == 0;
      req_addr = rnd_addr();
      load_addr = rnd_addr();
      load_data = $urandom;
      #1;
      exp_ready = !m_valid || rsp_ready;
      chk("rnd.ready", 32'(req_ready), 32'(exp_ready));
      if (req_valid && exp_ready) begin
        f = exp_fault(req_addr);
        m_valid = 1'b1;
        m_fault = f;
        m_instr = f != 2'b00 ? NOP_W : mem[req_addr / 4];
      end else if (rsp_ready) m_valid = 1'b0;
      f = exp_fault(load_addr);
      m_err = load_en && f != 2'b00;
      if (load_en && f == 2'b00) mem[load_addr / 4] = load_data;
      step();
      chk("rnd.valid", 32'(rsp_valid), 32'(m_valid));
      chk("rnd.load_err", 32'(load_err), 32'(m_err));
      if (m_valid) begin
        chk("rnd.instr", rsp_instr, m_instr);
        chk("rnd.fault", 32'(rsp_fault), 32'(m_fault));
      end
    end
    load_en = 1'b0;
    fetch("mid.fill", 32'h4, mem[1], 2'b00);
    rsp_ready = 1'b0;
    reset = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    load_en = 1'b1; load_addr = 32'h0; load_data = 32'h9999_9999;
    step();
    reset = 1'b0; req_valid = 1'b0; load_en = 1'b0;
    chk("mid.valid", 32'(rsp_valid), 32'd0);
    chk("mid.instr", rsp_instr, NOP_W);
    chk("mid.ready", 32'(req_ready), 32'd1);
    chk("mid.load_err", 32'(load_err), 32'd0);
    fetch("mid.word0", 32'h0, mem[0], 2'b00);
    fetch("mid.word15", 32'h3C, mem[15], 2'b00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
